// File: rtl/instruction_fetch_controller_if.sv
// Decode-side output stage handshake for the fetch controller.
// The master holds the registered word; the slave returns ready.
interface instruction_fetch_controller_if;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  modport master (
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// PC sequencer for a combinational imem feeding a one-entry
// valid/ready stage, with redirects and a sticky fetch fault.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  output logic [31:0]         imem_address_o,
  input  logic [31:0]         imem_instruction_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  instruction_fetch_controller_if.master out_if,
  output logic                fault_o,
  output logic [31:0]         fault_pc_o,
  output logic [31:0]         accepted_count_o
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic [31:0] r_count;

  logic w_transfer;
  logic w_can_load;

  function automatic logic illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_PC);
  endfunction

  assign w_transfer = r_valid & out_if.instr_ready_i;
  assign w_can_load = !r_valid || w_transfer;

  assign imem_address_o       = r_fetch_pc;
  assign out_if.instr_valid_o = r_valid;
  assign out_if.instr_o       = r_instr;
  assign out_if.pc_o          = r_pc;
  assign fault_o              = r_fault;
  assign fault_pc_o           = r_fault_pc;
  assign accepted_count_o     = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_count    <= '0;
    end else begin
      if (w_transfer)
        r_count <= r_count + 32'd1;
      unique case (r_state)
        RUN: begin
          if (redirect_i) begin
            r_valid <= 1'b0;
            if (illegal(redirect_pc_i)) begin
              r_state    <= FAULT;
              r_fault    <= 1'b1;
              r_fault_pc <= redirect_pc_i;
            end else begin
              r_fetch_pc <= redirect_pc_i;
            end
          end else if (enable_i && w_can_load) begin
            if (illegal(r_fetch_pc)) begin
              r_state    <= FAULT;
              r_fault    <= 1'b1;
              r_fault_pc <= r_fetch_pc;
              r_valid    <= 1'b0;
            end else begin
              r_instr    <= imem_instruction_i;
              r_pc       <= r_fetch_pc;
              r_valid    <= 1'b1;
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end else if (w_transfer) begin
            r_valid <= 1'b0;
          end
        end
        FAULT: begin
          r_valid <= 1'b0;
        end
        default: r_state <= FAULT;
      endcase
    end
  end

endmodule
